// File: rtl/special_op_pkg.sv
// Shared definitions for the memory-indirect special instructions.
//
// Holds the special-op code encoding (also used by the structural hazard
// unit when it issues LWi / SWi / memory-memory Add) and the state
// encoding of the special-op sequencer FSM.
package special_op_pkg;

    // 2-bit special-op codes issued by the structural hazard unit
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SWI  = 2'd1;
    localparam logic [1:0] OP_LWI  = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd3;

    // 3-bit sequencer state encoding
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/special_op_sequencer.sv
// Multi-cycle executor for LWi, SWi and memory-memory Add.
//
// A launch in IDLE latches the operands and drives the shared memory port
// for 2 transactions: a first read at addr_a, then either a second read
// (pointer for LWi, addr_b for Add) or a write of st_data through the
// pointer (SWi). busy stays high until the one-cycle DONE state, which
// raises done (and wb_en for LWi/Add) so the hazard unit can release the
// frozen pipeline.
//
// Ports:
//   clk, rest_n            clock, asynchronous active-low reset
//   op, start              special-op code and launch request (IDLE only)
//   addr_a, addr_b         operand / pointer addresses
//   st_data                SWi store data
//   flush                  abort; outstanding transaction completes first
//   busy, done, wb_en      status, completion pulse, writeback enable
//   result                 writeback value, held until the next done
//   mem_req/we/addr/wdata  registered memory request
//   mem_rdata, mem_ack     memory response
//   err                    timeout pulse (only with SPECIAL_SEQ_TIMEOUT_EN)
//
// Optional feature macro: SPECIAL_SEQ_TIMEOUT_EN adds a per-transaction
// wait counter that abandons a request after TIMEOUT unacknowledged cycles.
module special_op_sequencer
    import special_op_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
`ifdef SPECIAL_SEQ_TIMEOUT_EN
    output logic              err,
`endif
    input  logic              clk,
    input  logic              rest_n,
    input  logic [1:0]        op,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] st_data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              wb_en,
    output logic [DATA_W-1:0] result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    seq_state_t        state, state_nxt;
    logic [1:0]        op_q, op_nxt;
    logic [ADDR_W-1:0] addr_b_q, addr_b_nxt;
    logic [DATA_W-1:0] st_data_q, st_data_nxt;
    logic [DATA_W-1:0] tmp, tmp_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic              req_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    // A one-cycle flush pulse must survive until the outstanding ack.
    logic              flush_pend, flush_pend_nxt;
    logic              abort;

`ifdef SPECIAL_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             err_nxt;
`endif

    assign busy  = (state != S_IDLE);
    assign abort = flush | flush_pend;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            addr_b_q   <= '0;
            st_data_q  <= '0;
            tmp        <= '0;
            result     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            flush_pend <= 1'b0;
`ifdef SPECIAL_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            addr_b_q   <= addr_b_nxt;
            st_data_q  <= st_data_nxt;
            tmp        <= tmp_nxt;
            result     <= result_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            flush_pend <= flush_pend_nxt;
`ifdef SPECIAL_SEQ_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nxt;
            err        <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        op_nxt         = op_q;
        addr_b_nxt     = addr_b_q;
        st_data_nxt    = st_data_q;
        tmp_nxt        = tmp;
        result_nxt     = result;
        req_nxt        = mem_req;
        we_nxt         = mem_we;
        addr_nxt       = mem_addr;
        wdata_nxt      = mem_wdata;
        flush_pend_nxt = flush_pend;
        done           = 1'b0;
        wb_en          = 1'b0;
`ifdef SPECIAL_SEQ_TIMEOUT_EN
        wait_cnt_nxt   = wait_cnt;
        err_nxt        = 1'b0;
`endif

        unique case (state)
            S_IDLE: begin
                flush_pend_nxt = 1'b0;
                if (start && (op != OP_NONE) && !flush) begin
                    op_nxt      = op;
                    addr_b_nxt  = addr_b;
                    st_data_nxt = st_data;
                    state_nxt   = S_RD_A;
                    req_nxt     = 1'b1;
                    we_nxt      = 1'b0;
                    addr_nxt    = addr_a;
`ifdef SPECIAL_SEQ_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end

            S_RD_A, S_RD_B, S_WR: begin
                if (flush) flush_pend_nxt = 1'b1;
                if (mem_ack) begin
`ifdef SPECIAL_SEQ_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                    if (abort) begin
                        // Transaction finished (a write has landed); drop the data.
                        state_nxt      = S_IDLE;
                        req_nxt        = 1'b0;
                        we_nxt         = 1'b0;
                        flush_pend_nxt = 1'b0;
                    end else if (state == S_RD_A) begin
                        tmp_nxt = mem_rdata;
                        // Back-to-back: mem_req stays high into the next transaction.
                        if (op_q == OP_SWI) begin
                            state_nxt = S_WR;
                            we_nxt    = 1'b1;
                            addr_nxt  = mem_rdata[ADDR_W-1:0];
                            wdata_nxt = st_data_q;
                        end else begin
                            state_nxt = S_RD_B;
                            addr_nxt  = (op_q == OP_LWI) ? mem_rdata[ADDR_W-1:0] : addr_b_q;
                        end
                    end else begin
                        if (state == S_RD_B)
                            result_nxt = (op_q == OP_LWI) ? mem_rdata : tmp + mem_rdata;
                        state_nxt = S_DONE;
                        req_nxt   = 1'b0;
                        we_nxt    = 1'b0;
                    end
                end else begin
`ifdef SPECIAL_SEQ_TIMEOUT_EN
                    if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt      = S_IDLE;
                        req_nxt        = 1'b0;
                        we_nxt         = 1'b0;
                        flush_pend_nxt = 1'b0;
                        err_nxt        = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
`endif
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
                if (!abort) begin
                    done  = 1'b1;
                    wb_en = (op_q != OP_SWI);
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
